// File: rtl/i2s_pkg.sv
// Shared defaults and types for the I2S microphone capture front-end.
package i2s_pkg;

  localparam int CLK_DIV_DEF     = 16;
  localparam int SAMPLE_BITS_DEF = 24;
  localparam int SLOT_BITS_DEF   = 32;
  localparam int FIFO_DEPTH_DEF  = 8;

  typedef logic [SAMPLE_BITS_DEF-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word fall-through sample FIFO with wrap-bit pointers and a drop strobe
// for pushes that find no room.
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = SAMPLE_BITS_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       ready,
  output logic [WIDTH-1:0]           data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             empty_s;
  logic             pop_s;
  logic             push_ok_s;

  // Status, handshake qualification and head presentation
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full      = ((wr_ptr_r ^ rd_ptr_r) == PW'(DEPTH));
    pop_s     = !empty_s && ready;
    push_ok_s = push && (!full || pop_s);
    drop      = push && full && !pop_s;
    valid     = !empty_s;
    level     = wr_ptr_r - rd_ptr_r;
    if (empty_s) begin
      data = '0;
    end else begin
      data = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Pointer update; a full FIFO still accepts a push when the head leaves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/i2s_mic_capture.sv
// I2S master for a MEMS microphone: bit clock / word select generation, left
// slot deserialization and buffering of completed samples.
module i2s_mic_capture
  import i2s_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int SLOT_BITS   = SLOT_BITS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic                          i2s_clk,
  output logic                          i2s_ws,
  input  logic                          i2s_sd,
  output logic [SAMPLE_BITS-1:0]        sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LSB  = BIT_W'(SAMPLE_BITS);

  logic [DIV_W-1:0]       div_cnt_r;
  logic                   i2s_clk_r;
  logic                   i2s_ws_r;
  logic [BIT_W-1:0]       bit_idx_r;
  logic [SAMPLE_BITS-2:0] shift_r;
  logic                   push_r;
  logic [SAMPLE_BITS-1:0] push_data_r;
  logic                   overflow_r;
  logic                   rise_s;
  logic                   fall_s;
  logic                   capture_s;
  logic                   complete_s;
  logic [BIT_W-1:0]       bit_next_s;
  logic                   fifo_drop_s;
  logic                   fifo_full_s;

  // Bit clock edge events and capture window decode
  always_comb begin
    rise_s     = 1'b0;
    fall_s     = 1'b0;
    bit_next_s = bit_idx_r;
    if (en && (div_cnt_r == DIV_LAST)) begin
      rise_s = !i2s_clk_r;
      fall_s = i2s_clk_r;
    end else begin
      rise_s = 1'b0;
      fall_s = 1'b0;
    end
    if (bit_idx_r == BIT_LAST) begin
      bit_next_s = '0;
    end else begin
      bit_next_s = bit_idx_r + BIT_W'(1);
    end
    capture_s  = rise_s && (bit_idx_r >= BIT_MSB) && (bit_idx_r <= BIT_LSB);
    complete_s = capture_s && (bit_idx_r == BIT_LSB);
  end

  // Divider, frame counter, shifter; a completed word survives a late disable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r   <= '0;
      i2s_clk_r   <= 1'b0;
      i2s_ws_r    <= 1'b0;
      bit_idx_r   <= '0;
      shift_r     <= '0;
      push_r      <= 1'b0;
      push_data_r <= '0;
    end else begin
      push_r <= complete_s;
      if (complete_s) begin
        push_data_r <= {shift_r, i2s_sd};
      end
      if (!en) begin
        div_cnt_r <= '0;
        i2s_clk_r <= 1'b0;
        i2s_ws_r  <= 1'b0;
        bit_idx_r <= '0;
        shift_r   <= '0;
      end else begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_r <= '0;
        end else begin
          div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
        if (rise_s) begin
          i2s_clk_r <= 1'b1;
        end else if (fall_s) begin
          i2s_clk_r <= 1'b0;
          bit_idx_r <= bit_next_s;
          i2s_ws_r  <= (bit_next_s >= BIT_SLOT);
        end
        if (capture_s) begin
          shift_r <= {shift_r[SAMPLE_BITS-3:0], i2s_sd};
        end
      end
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (fifo_drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  sample_fifo #(
    .WIDTH (SAMPLE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_r),
    .push_data (push_data_r),
    .ready     (sample_ready),
    .data      (sample_data),
    .valid     (sample_valid),
    .full      (fifo_full_s),
    .level     (fifo_level),
    .drop      (fifo_drop_s)
  );

  assign i2s_clk  = i2s_clk_r;
  assign i2s_ws   = i2s_ws_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Directed bench for i2s_mic_capture: clocking, capture latency, overflow,
// full-with-pop, mid-frame disable and mid-frame reset.
module tb_i2s_mic_capture;
  import i2s_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        i2s_clk;
  logic        i2s_ws;
  logic        i2s_sd = 1'b0;
  logic [23:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        clear_overflow;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rises_n     = 0;
  int falls_n     = 0;
  logic prev_clk  = 1'b0;
  logic prev_ws   = 1'b0;

  sample_t mic_tab [16];
  sample_t drain_exp [8];
  sample_t mic_cur;
  int      mic_bit   = 0;
  int      mic_frame = 0;

  i2s_mic_capture dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .i2s_clk        (i2s_clk),
    .i2s_ws         (i2s_ws),
    .i2s_sd         (i2s_sd),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Microphone model: left word MSB-first with one-bit delay, right slot all ones
  always @(negedge i2s_clk or negedge rst or negedge en) begin
    if (!rst || !en) begin
      mic_bit   = 0;
      mic_frame = 0;
      i2s_sd    = 1'b0;
    end else begin
      if (mic_bit == 63) begin
        mic_bit = 0;
        mic_frame++;
      end else begin
        mic_bit++;
      end
      mic_cur = mic_tab[mic_frame % 16];
      if (mic_bit >= 1 && mic_bit <= 24) i2s_sd = mic_cur[24 - mic_bit];
      else if (mic_bit >= 33 && mic_bit <= 56) i2s_sd = 1'b1;
      else i2s_sd = 1'b0;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock, sampled on the falling edge; tracks bit clock edges and word select
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!en || !rst) begin
      rises_n = 0;
      falls_n = 0;
    end else begin
      if (!prev_clk && i2s_clk) rises_n++;
      if (prev_clk && !i2s_clk) begin
        falls_n++;
        check_value("ws_at_fall", {31'b0, i2s_ws}, {31'b0, (falls_n % 64) >= 32});
      end else if (i2s_ws !== prev_ws) begin
        check_value("ws_off_fall", {31'b0, i2s_ws}, {31'b0, prev_ws});
      end
    end
    prev_clk = i2s_clk;
    prev_ws  = i2s_ws;
  endtask

  task automatic wait_rises(input int n);
    int limit;
    int guard;
    limit = (n - rises_n) * 32 + 64;
    guard = 0;
    while (rises_n < n && guard < limit) begin
      tick();
      guard++;
    end
    if (rises_n < n) check_value("rise_timeout", rises_n, n);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_clk"},   {31'b0, i2s_clk}, 32'd0);
    check_value({tag, "_ws"},    {31'b0, i2s_ws}, 32'd0);
    check_value({tag, "_valid"}, {31'b0, sample_valid}, 32'd0);
    check_value({tag, "_data"},  {8'b0, sample_data}, 32'd0);
    check_value({tag, "_level"}, {28'b0, fifo_level}, 32'd0);
    check_value({tag, "_ovf"},   {31'b0, overflow}, 32'd0);
  endtask

  initial begin
    int n;
    int t0;
    rst = 1'b0;
    en = 1'b0;
    sample_ready = 1'b0;
    clear_overflow = 1'b0;
    for (int i = 0; i < 16; i++) mic_tab[i] = sample_t'(24'hC0FFEE ^ (i * 24'h111111));
    mic_tab[0] = 24'hA5C3F1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // Clock generation and serial capture
    en = 1'b1;
    n = 0;
    while (rises_n < 1 && n < 100) begin
      tick();
      n++;
    end
    check_value("first_rise", n, 32'd16);
    t0 = cyc;
    wait_rises(2);
    check_value("clk_period", cyc - t0, 32'd32);
    wait_rises(25);
    check_value("valid_early", {31'b0, sample_valid}, 32'd0);
    tick();
    check_value("valid_lat", {31'b0, sample_valid}, 32'd1);
    check_value("cap_data", {8'b0, sample_data}, 32'hA5C3F1);
    wait_rises(64 + 64 + 2);
    check_value("level_two", {28'b0, fifo_level}, 32'd2);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Overflow, set-wins clear and full-with-pop
    mic_tab[0] = 24'hC0FFEE;
    en = 1'b1;
    wait_rises(64 * 7 + 25);
    tick();
    check_value("lvl_8", {28'b0, fifo_level}, 32'd8);
    check_value("ovf_8", {31'b0, overflow}, 32'd0);
    wait_rises(64 * 8 + 25);
    tick();
    check_value("ovf_9", {31'b0, overflow}, 32'd1);
    check_value("lvl_9", {28'b0, fifo_level}, 32'd8);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_value("ovf_clr", {31'b0, overflow}, 32'd0);
    wait_rises(64 * 9 + 25);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_value("ovf_set_wins", {31'b0, overflow}, 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_value("ovf_clr2", {31'b0, overflow}, 32'd0);
    wait_rises(64 * 10 + 25);
    check_value("full_head", {8'b0, sample_data}, {8'b0, mic_tab[0]});
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    check_value("fullpop_lvl", {28'b0, fifo_level}, 32'd8);
    check_value("fullpop_ovf", {31'b0, overflow}, 32'd0);
    en = 1'b0;
    repeat (2) tick();
    check_value("dis_clk", {31'b0, i2s_clk}, 32'd0);
    check_value("dis_ws", {31'b0, i2s_ws}, 32'd0);
    check_value("dis_valid", {31'b0, sample_valid}, 32'd1);
    for (int k = 0; k < 7; k++) drain_exp[k] = mic_tab[k + 1];
    drain_exp[7] = mic_tab[10];
    sample_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_value($sformatf("drain%0d", k), {8'b0, sample_data}, {8'b0, drain_exp[k]});
      tick();
    end
    sample_ready = 1'b0;
    check_value("drain_empty", {31'b0, sample_valid}, 32'd0);
    check_value("drain_lvl", {28'b0, fifo_level}, 32'd0);

    // Mid-frame disable and restart
    mic_tab[0] = 24'h5A3C0F;
    en = 1'b1;
    wait_rises(13);
    en = 1'b0;
    repeat (100) tick();
    check_idle_outputs("middis");
    mic_tab[0] = 24'h3C5A96;
    en = 1'b1;
    wait_rises(25);
    tick();
    check_value("restart_valid", {31'b0, sample_valid}, 32'd1);
    check_value("restart_data", {8'b0, sample_data}, 32'h3C5A96);
    check_value("restart_lvl", {28'b0, fifo_level}, 32'd1);

    // Reset mid-frame with three entries queued
    wait_rises(64 + 25);
    wait_rises(128 + 25);
    tick();
    check_value("pre_rst_lvl", {28'b0, fifo_level}, 32'd3);
    wait_rises(128 + 40);
    check_value("pre_rst_ws", {31'b0, i2s_ws}, 32'd1);
    rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    tick();
    rst = 1'b1;
    tick();
    check_value("post_rst_lvl", {28'b0, fifo_level}, 32'd0);
    check_value("post_rst_valid", {31'b0, sample_valid}, 32'd0);
    en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_mic_capture.md
# i2s_mic_capture

Audio front-end for the zedboard capture design. Generates the I2S bit clock and word select for the MEMS microphone, deserializes the left-channel sample from `i2s_sd`, and buffers completed samples in a small FIFO. The FIFO is read through a valid/ready port by the downstream stage that forwards samples to the DRAM wrapper / SPI path.

## Interface
Parameters:
- `CLK_DIV`, 16: `clk` cycles per half period of `i2s_clk`; must be ≥ 2. At 50 MHz this gives a 1.5625 MHz bit clock and a 24.414 kHz frame rate.
- `SAMPLE_BITS`, 24: captured bits per sample, MSB first; must be ≤ `SLOT_BITS`-1.
- `SLOT_BITS`, 32: bit clocks per channel slot; a frame is 2×`SLOT_BITS`.
- `FIFO_DEPTH`, 8: sample FIFO entries; must be a power of two.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: capture enable.
- `i2s_clk`, out, 1: I2S bit clock.
- `i2s_ws`, out, 1: word select; 0 = left slot, 1 = right slot.
- `i2s_sd`, in, 1: serial data from the microphone.
- `sample_data`, out, `SAMPLE_BITS`: FIFO head; raw two's complement.
- `sample_valid`, out, 1: FIFO not empty.
- `sample_ready`, in, 1: consumer accepts the head.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current number of entries.
- `overflow`, out, 1: sticky flag; a completed sample was dropped.
- `clear_overflow`, in, 1: clears `overflow`.

## Operation
- Divider: `div_cnt` counts 0..`CLK_DIV`-1. On wrap, `i2s_clk` toggles. Each toggle is a rise event (0→1) or a fall event (1→0).
- Bit counter: `bit_idx` counts 0..2×`SLOT_BITS`-1 and advances on each fall event.
- Word select: `i2s_ws` = (`bit_idx` ≥ `SLOT_BITS`), registered so it changes with the fall event.
- Bit delay: I2S one-bit delay applies. The MSB of the left sample is present during `bit_idx` = 1, and the LSB during `bit_idx` = `SAMPLE_BITS`.
- Sampling: `i2s_sd` is sampled in the `clk` cycle of the rise event. For `bit_idx` in 1..`SAMPLE_BITS`, the bit is shifted into `shift_reg` (left shift, LSB in).
- Completion: the rise event at `bit_idx` = `SAMPLE_BITS` completes the sample. The full word is pushed into the FIFO in the next cycle. Right slot bits are ignored.
- Enable low: `i2s_clk`, `i2s_ws`, `div_cnt`, `bit_idx` and `shift_reg` are held at 0. Contents of the FIFO are retained and remain readable.
- Enable rising: the frame restarts at `bit_idx` = 0 with `i2s_clk` low.
- Enable falling mid-frame: the partial sample is discarded and nothing is pushed.
- FIFO is first-word fall-through: `sample_data` is valid whenever `sample_valid` = 1. A pop occurs on `sample_valid && sample_ready`.
- Push while full:
  - With a pop in the same cycle, the push is accepted and the level is unchanged.
  - Without a pop, the sample is dropped and `overflow` is set.
- Push while empty: `sample_valid` rises one cycle after the push.
- `clear_overflow` clears `overflow`. If `clear_overflow` and a new drop occur in the same cycle, the set wins.

## Timing
- Reset values: `i2s_clk`=0, `i2s_ws`=0, `sample_valid`=0, `sample_data`=0, `fifo_level`=0, `overflow`=0. All internal counters and pointers are 0.
- Reset assertion is asynchronous at any point. Any in-flight sample and all FIFO contents are discarded.
- Bit clock period: 2×`CLK_DIV` `clk` cycles. The first rise event occurs `CLK_DIV` cycles after `en` goes high.
- Frame period: 4×`CLK_DIV`×`SLOT_BITS` cycles (2048 at defaults).
- Latency: `sample_valid` asserts 2 cycles after the capture rise event for `bit_idx` = `SAMPLE_BITS` (push register plus FIFO write).
- Pointers: FIFO pointers carry one extra wrap bit.
  - full = (`wr_ptr` ^ `rd_ptr`) == `FIFO_DEPTH`.
  - empty = (`wr_ptr` == `rd_ptr`).
  - `fifo_level` = `wr_ptr` − `rd_ptr`, modulo 2^($clog2(FIFO_DEPTH)+1).

## Structure
- Package `i2s_pkg`:
  - Defaults for `CLK_DIV`, `SAMPLE_BITS`, `SLOT_BITS` and `FIFO_DEPTH`.
  - `typedef logic [SAMPLE_BITS-1:0] sample_t`.
- Sub-module `sample_fifo`: parameterized FWFT FIFO providing push/pop, full/empty, level and the overflow drop signal. It is also reusable by the SPI path.
- The divider, bit counter and shifter stay in `i2s_mic_capture`.

## Test plan
- Clock generation: reset, then `en`=1 with `CLK_DIV`=16. Required: `i2s_clk` period of 32 cycles, `i2s_ws` high for 32 bit clocks then low for 32, and `i2s_ws` edges coincident with `i2s_clk` fall events.
- Serial capture: a mic model drives 0xA5C3F1 MSB-first after the left-slot `i2s_ws` fall with a one-bit delay. Required: `sample_data`=0xA5C3F1 and `sample_valid` 2 cycles after the 24th left-slot capture rise event. Right-slot data 0xFFFFFF is ignored.
- Overflow: hold `sample_ready`=0 for 10 frames. Required: `fifo_level` saturates at 8 and `overflow`=1 after the 9th sample. Draining then yields samples 1..8 in order. A `clear_overflow` pulse clears the flag.
- Full plus simultaneous pop: with the FIFO full, assert `sample_ready` in the push cycle. Required: push accepted, `fifo_level` stays 8, `overflow` stays 0.
- Mid-frame disable: drop `en` at `bit_idx`=12 and re-enable after 100 cycles. Required: no partial push, outputs held at 0 while disabled, and the next sample is captured correctly from the new frame start.
- Reset mid-frame: assert `rst`=0 with 3 entries in the FIFO. Required: all outputs return to reset values immediately, and `fifo_level`=0 after release.
